// File: rtl/display_scheduler.sv
// Purpose: selects which BCD value the 4-digit display shows, runs the view/set FSM, blink and idle timeout, and paces digit scanning.
// Latency: digit outputs are registered, 1 cycle from an input or view change; refresh_en and view come straight from state registers.
// Backpressure: none; button and tick pulses are sampled on every clk edge and cannot be stalled.
module display_scheduler #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_HALF  = 25000000,
    parameter int TIMEOUT_S   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_btn,
    input  logic        set_btn,
    input  logic        sec_tick,
    input  logic [15:0] time_bcd,
    input  logic [15:0] sw_bcd,
    input  logic [15:0] alarm_bcd,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic        refresh_en,
    output logic [2:0]  view
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_HALF - 1);
    localparam logic [IW-1:0] IMAX = IW'(TIMEOUT_S);

    localparam logic [3:0] BLANK = 4'd10;

    typedef enum logic [2:0] {
        S_TIME    = 3'd0,
        S_SW      = 3'd1,
        S_ALARM   = 3'd2,
        S_SET_HR  = 3'd3,
        S_SET_MIN = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    logic          blink_vis;
    logic [IW-1:0] idle_cnt;

    logic          any_btn;
    logic          mode_eff;
    logic          in_set;
    logic          in_timed;
    logic          timeout;
    logic          state_chg;
    logic          set_entry;

    logic [15:0]   src;
    logic [3:0]    d3_n, d2_n, d1_n, d0_n;

    // Anything above 9 is not a numeral, so show it as blank.
    function automatic logic [3:0] clamp(input logic [3:0] n);
        return (n > 4'd9) ? BLANK : n;
    endfunction

    // A simultaneous set_btn swallows mode_btn; a button in the timeout cycle beats the timeout.
    assign any_btn   = mode_btn | set_btn;
    assign mode_eff  = mode_btn & ~set_btn;
    assign in_set    = (state == S_SET_HR) || (state == S_SET_MIN);
    assign in_timed  = in_set || (state == S_ALARM);
    assign timeout   = in_timed && (idle_cnt == IMAX) && !any_btn;
    assign state_chg = (state_nxt != state);
    assign set_entry = state_chg && ((state_nxt == S_SET_HR) || (state_nxt == S_SET_MIN));

    assign view       = state;
    assign refresh_en = rst_n && (rcnt == RMAX);

    // Scan pacing counter, wraps at REFRESH_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
        end else if (rcnt == RMAX) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end

    // View state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_TIME;
        end else begin
            state <= state_nxt;
        end
    end

    // Next view: mode cycles the display views, set walks the set sequence, idle timeout falls back to TIME.
    always_comb begin
        state_nxt = state;
        case (state)
            S_TIME: begin
                if (set_btn)       state_nxt = S_SET_HR;
                else if (mode_eff) state_nxt = S_SW;
            end
            S_SW: begin
                if (mode_eff) state_nxt = S_ALARM;
            end
            S_ALARM: begin
                if (mode_eff || timeout) state_nxt = S_TIME;
            end
            S_SET_HR: begin
                if (set_btn)      state_nxt = S_SET_MIN;
                else if (timeout) state_nxt = S_TIME;
            end
            S_SET_MIN: begin
                if (set_btn || timeout) state_nxt = S_TIME;
            end
            default: state_nxt = S_TIME;
        endcase
    end

    // Idle seconds since last activity; saturates at TIMEOUT_S so the timeout stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (any_btn || state_chg) begin
            idle_cnt <= '0;
        end else if (sec_tick && in_timed && (idle_cnt != IMAX)) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // Blink phase for the field being set; restarts visible on entry and on any button press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt      <= '0;
            blink_vis <= 1'b1;
        end else if (any_btn || set_entry) begin
            bcnt      <= '0;
            blink_vis <= 1'b1;
        end else if (in_set) begin
            if (bcnt == BMAX) begin
                bcnt      <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end else begin
            bcnt      <= '0;
            blink_vis <= 1'b1;
        end
    end

    // Source select plus blanking rules for the next digit codes.
    always_comb begin
        case (state)
            S_SW:    src = sw_bcd;
            S_ALARM: src = alarm_bcd;
            default: src = time_bcd;
        endcase
        d3_n = clamp(src[15:12]);
        d2_n = clamp(src[11:8]);
        d1_n = clamp(src[7:4]);
        d0_n = clamp(src[3:0]);
        if ((state == S_TIME) && (src[15:12] == 4'd0)) begin
            d3_n = BLANK;
        end
        if ((state == S_SET_HR) && !blink_vis) begin
            d3_n = BLANK;
            d2_n = BLANK;
        end
        if ((state == S_SET_MIN) && !blink_vis) begin
            d1_n = BLANK;
            d0_n = BLANK;
        end
    end

    // Registered digit outputs; blank while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thousands <= BLANK;
            hundreds  <= BLANK;
            tens      <= BLANK;
            ones      <= BLANK;
        end else begin
            thousands <= d3_n;
            hundreds  <= d2_n;
            tens      <= d1_n;
            ones      <= d0_n;
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Purpose: self-checking bench for display_scheduler with small parameters.
// Latency: compares every falling edge against a reference model; directed literal checks pin the model.
// Backpressure: none; pulses are driven 2 time units after rising edges.
module tb_display_scheduler;

    localparam int DIV = 4;
    localparam int BH  = 2;
    localparam int TO  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode_btn = 1'b0;
    logic        set_btn = 1'b0;
    logic        sec_tick = 1'b0;
    logic [15:0] time_bcd = 16'h0945;
    logic [15:0] sw_bcd = 16'h1A23;
    logic [15:0] alarm_bcd = 16'h0630;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic        refresh_en;
    logic [2:0]  view;

    int errors = 0;
    int checks = 0;

    display_scheduler #(
        .REFRESH_DIV(DIV),
        .BLINK_HALF (BH),
        .TIMEOUT_S  (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_btn  (mode_btn),
        .set_btn   (set_btn),
        .sec_tick  (sec_tick),
        .time_bcd  (time_bcd),
        .sw_bcd    (sw_bcd),
        .alarm_bcd (alarm_bcd),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .refresh_en(refresh_en),
        .view      (view)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Views: 0 time, 1 stopwatch, 2 alarm, 3 set hours, 4 set minutes.
    int m_view   = 0;
    int m_idle   = 0;   // seconds ticked since last activity, saturating
    int m_bsince = 0;   // cycles since the blink last restarted
    int m_cyc    = 0;   // edges since reset release
    int m_dig [4] = '{10, 10, 10, 10};

    function automatic int shown(input int v, input logic [15:0] t, input logic [15:0] s,
                                 input logic [15:0] a, input int vis, input int pos);
        logic [15:0] src;
        int n;
        src = (v == 1) ? s : (v == 2) ? a : t;
        n = int'((src >> (4 * pos)) & 16'hF);
        if (n > 9) n = 10;
        if (v == 0 && pos == 3 && n == 0) n = 10;
        if (v == 3 && vis == 0 && pos >= 2) n = 10;
        if (v == 4 && vis == 0 && pos <= 1) n = 10;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_view = 0; m_idle = 0; m_bsince = 0; m_cyc = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = 10;
        end else begin
            int nv;
            bit btn;
            bit mo;
            int vis;
            btn = mode_btn || set_btn;
            mo  = mode_btn && !set_btn;
            vis = ((m_bsince / BH) % 2 == 0) ? 1 : 0;
            for (int k = 0; k < 4; k++)
                m_dig[k] = shown(m_view, time_bcd, sw_bcd, alarm_bcd, vis, k);
            nv = m_view;
            if (m_view == 0) begin
                if (set_btn) nv = 3; else if (mo) nv = 1;
            end else if (m_view == 1) begin
                if (mo) nv = 2;
            end else if (m_view == 2) begin
                if (mo) nv = 0; else if (!btn && m_idle == TO) nv = 0;
            end else if (m_view == 3) begin
                if (set_btn) nv = 4; else if (!btn && m_idle == TO) nv = 0;
            end else begin
                if (set_btn) nv = 0; else if (!btn && m_idle == TO) nv = 0;
            end
            if (btn || nv != m_view) m_idle = 0;
            else if (sec_tick && m_view >= 2 && m_idle < TO) m_idle = m_idle + 1;
            if (btn || (nv != m_view && nv >= 3)) m_bsince = 0;
            else if (m_view >= 3) m_bsince = m_bsince + 1;
            else m_bsince = 0;
            m_cyc  = m_cyc + 1;
            m_view = nv;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_view", int'(view), m_view);
        chk("model_refresh", int'(refresh_en), (rst_n && (m_cyc % DIV == DIV - 1)) ? 1 : 0);
        chk("model_thousands", int'(thousands), m_dig[3]);
        chk("model_hundreds", int'(hundreds), m_dig[2]);
        chk("model_tens", int'(tens), m_dig[1]);
        chk("model_ones", int'(ones), m_dig[0]);
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input bit m, input bit s, input bit t);
        @(posedge clk); #2;
        mode_btn = m; set_btn = s; sec_tick = t;
        @(posedge clk); #2;
        mode_btn = 1'b0; set_btn = 1'b0; sec_tick = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_digits(input string name, input int d3, input int d2, input int d1, input int d0);
        chk({name, "_thousands"}, int'(thousands), d3);
        chk({name, "_hundreds"}, int'(hundreds), d2);
        chk({name, "_tens"}, int'(tens), d1);
        chk({name, "_ones"}, int'(ones), d0);
    endtask

    initial begin
        int hi_exp [6];
        int lo_exp [6];
        hi_exp = '{0, 0, 10, 10, 0, 0};
        lo_exp = '{4, 4, 10, 10, 4, 4};

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_digits("reset", 10, 10, 10, 10);
        chk("reset_view", int'(view), 0);
        chk("reset_refresh", int'(refresh_en), 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("refresh_cycle", int'(refresh_en), ((i % 4) == 3) ? 1 : 0);
            @(negedge clk);
        end
        chk_digits("time_0945", 10, 9, 4, 5);

        pulse(1, 0, 0);
        chk("mode1_view", int'(view), 1);
        step(1);
        chk_digits("stopwatch", 1, 10, 2, 3);
        pulse(1, 0, 0);
        chk("mode2_view", int'(view), 2);
        step(1);
        chk_digits("alarm_no_lz_blank", 0, 6, 3, 0);
        pulse(1, 0, 0);
        chk("mode3_view", int'(view), 0);

        time_bcd = 16'h1B7C;
        step(1);
        chk_digits("time_nibble_gt9", 1, 10, 7, 10);
        time_bcd = 16'h0945;

        pulse(1, 0, 0);
        pulse(1, 0, 0);
        chk("alarm_again_view", int'(view), 2);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        step(1);
        chk("timeout_view", int'(view), 0);

        pulse(0, 1, 0);
        chk("set_hr_view", int'(view), 3);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        pulse(0, 1, 1);
        chk("set_beats_timeout_view", int'(view), 4);
        step(4);
        chk("set_min_holds_view", int'(view), 4);

        pulse(1, 1, 0);
        chk("both_in_set_min_view", int'(view), 0);
        pulse(1, 1, 0);
        chk("both_in_time_view", int'(view), 3);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("blink_hr_thousands", int'(thousands), hi_exp[i]);
            chk("blink_hr_hundreds", int'(hundreds), (hi_exp[i] == 10) ? 10 : 9);
            chk("blink_hr_tens", int'(tens), 4);
            chk("blink_hr_ones", int'(ones), 5);
        end

        pulse(0, 1, 0);
        chk("set_min_view", int'(view), 4);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("blink_min_thousands", int'(thousands), 0);
            chk("blink_min_hundreds", int'(hundreds), 9);
            chk("blink_min_tens", int'(tens), lo_exp[i]);
            chk("blink_min_ones", int'(ones), (lo_exp[i] == 10) ? 10 : 5);
        end

        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_digits("async_reset", 10, 10, 10, 10);
        chk("async_reset_view", int'(view), 0);
        chk("async_reset_refresh", int'(refresh_en), 0);
        @(negedge clk);
        rst_n = 1'b1;

        pulse(1, 0, 0);
        chk("post_reset_mode_view", int'(view), 1);
        step(1);
        chk_digits("post_reset_stopwatch", 1, 10, 2, 3);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
